spi_input_conditioner: RTL and testbench

//  Front end of the SPI slave. Takes the asynchronous SCLK, CS and MOSI pins and

---
 rtl/spi_input_conditioner_pkg.sv | 28 ++
 rtl/spi_input_conditioner_cond.sv | 80 ++++++++
 rtl/spi_input_conditioner.sv | 133 +++++++++++++
 tb/tb_spi_input_conditioner.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_input_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// spi_input_conditioner_pkg
// Shared definitions for the SPI slave pin front end:
//   - idle levels of the SCLK / CS / MOSI pins (the values that reset forces)
//   - default debounce wait time
//   - channel enumeration used to index per-channel vectors
//   - small helper to count how many channels assert a flag in one cycle
// ---------------------------------------------------------------------------
package spi_input_conditioner_pkg;

    localparam logic SPI_SCLK_IDLE = 1'b0;
    localparam logic SPI_CS_IDLE   = 1'b1;
    localparam logic SPI_MOSI_IDLE = 1'b0;

    localparam int SPI_COND_WAIT = 3;

    typedef enum logic [1:0] {
        CH_SCLK = 2'd0,
        CH_CS   = 2'd1,
        CH_MOSI = 2'd2
    } spi_chan_e;

    // Number of set bits in a 3-bit vector (0..3).
    function automatic logic [1:0] count3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/spi_input_conditioner_cond.sv
// ---------------------------------------------------------------------------
// input_conditioner
// One pin channel: 2-FF synchroniser, stable-count debounce filter and edge
// detector.
//
// Parameters
//   WAIT_TIME  cycles the synchronised level must differ from the conditioned
//              level before it is accepted (1..255)
//   CNT_W      width of the debounce counter (2**CNT_W > WAIT_TIME)
//   IDLE       level the synchroniser and conditioned output take in reset
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   noisy        in   raw asynchronous pin
//   conditioned  out  debounced level
//   posedge_p    out  registered 1-cycle pulse on accepted 0->1
//   negedge_p    out  registered 1-cycle pulse on accepted 1->0
//   reject_p     out  high while a pending change is being abandoned
//                     (synchronised level is back at the conditioned level
//                     but the counter has not yet been cleared)
// ---------------------------------------------------------------------------
module input_conditioner
    import spi_input_conditioner_pkg::*;
#(
    parameter int   WAIT_TIME = SPI_COND_WAIT,
    parameter int   CNT_W     = 8,
    parameter logic IDLE      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic noisy,
    output logic conditioned,
    output logic posedge_p,
    output logic negedge_p,
    output logic reject_p
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIME - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_cond;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pos;
    logic             r_neg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync0 <= IDLE;
            r_sync1 <= IDLE;
            r_cond  <= IDLE;
            r_cnt   <= '0;
            r_pos   <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            r_sync0 <= noisy;
            r_sync1 <= r_sync0;
            r_pos   <= 1'b0;
            r_neg   <= 1'b0;
            if (r_sync1 == r_cond) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // Level has differed for WAIT_TIME consecutive cycles: accept it.
                r_cond <= r_sync1;
                r_cnt  <= '0;
                r_pos  <= r_sync1;
                r_neg  <= ~r_sync1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign conditioned = r_cond;
    assign posedge_p   = r_pos;
    assign negedge_p   = r_neg;
    assign reject_p    = (r_sync1 == r_cond) && (r_cnt != '0);

endmodule

// File: rtl/spi_input_conditioner.sv
// ---------------------------------------------------------------------------
// spi_input_conditioner
// Front end of the SPI slave: synchronises, debounces and edge-detects the
// asynchronous SCLK, CS and MOSI pins into clean clk-domain signals.
//
// Optional feature macro: SPI_COND_GLITCH_CNT_EN
//   When defined, adds parameter GLITCH_W and output glitch_cnt, a saturating
//   count of rejected glitches across all three channels (cleared by reset).
//
// Parameters
//   WAIT_TIME  debounce wait in cycles (1..255)
//   CNT_W      per-channel debounce counter width (2**CNT_W > WAIT_TIME)
//   GLITCH_W   glitch_cnt width (only with SPI_COND_GLITCH_CNT_EN)
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous active-high reset
//   sclk_pin      in   raw serial clock pin
//   cs_pin        in   raw chip select pin (active-low)
//   mosi_pin      in   raw MOSI pin
//   sclk_posedge  out  1-cycle pulse on accepted SCLK rise
//   sclk_negedge  out  1-cycle pulse on accepted SCLK fall
//   cs_cond       out  conditioned chip select level
//   mosi_cond     out  conditioned MOSI level
//   glitch_cnt    out  rejected-glitch count (only with SPI_COND_GLITCH_CNT_EN)
// ---------------------------------------------------------------------------
module spi_input_conditioner
    import spi_input_conditioner_pkg::*;
#(
    parameter int WAIT_TIME = SPI_COND_WAIT,
    parameter int CNT_W     = 8
`ifdef SPI_COND_GLITCH_CNT_EN
    ,
    parameter int GLITCH_W  = 8
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sclk_pin,
    input  logic                cs_pin,
    input  logic                mosi_pin,
    output logic                sclk_posedge,
    output logic                sclk_negedge,
    output logic                cs_cond,
    output logic                mosi_cond
`ifdef SPI_COND_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

`ifdef SPI_COND_GLITCH_CNT_EN
    logic [2:0] w_reject;
`endif

    // SCLK: only the edges are consumed downstream, the level is not.
    input_conditioner #(
        .WAIT_TIME (WAIT_TIME),
        .CNT_W     (CNT_W),
        .IDLE      (SPI_SCLK_IDLE)
    ) u_sclk (
        .clk         (clk),
        .reset       (reset),
        .noisy       (sclk_pin),
        .conditioned (),
        .posedge_p   (sclk_posedge),
        .negedge_p   (sclk_negedge),
`ifdef SPI_COND_GLITCH_CNT_EN
        .reject_p    (w_reject[CH_SCLK])
`else
        .reject_p    ()
`endif
    );

    // CS and MOSI: only the levels are consumed downstream.
    input_conditioner #(
        .WAIT_TIME (WAIT_TIME),
        .CNT_W     (CNT_W),
        .IDLE      (SPI_CS_IDLE)
    ) u_cs (
        .clk         (clk),
        .reset       (reset),
        .noisy       (cs_pin),
        .conditioned (cs_cond),
        .posedge_p   (),
        .negedge_p   (),
`ifdef SPI_COND_GLITCH_CNT_EN
        .reject_p    (w_reject[CH_CS])
`else
        .reject_p    ()
`endif
    );

    input_conditioner #(
        .WAIT_TIME (WAIT_TIME),
        .CNT_W     (CNT_W),
        .IDLE      (SPI_MOSI_IDLE)
    ) u_mosi (
        .clk         (clk),
        .reset       (reset),
        .noisy       (mosi_pin),
        .conditioned (mosi_cond),
        .posedge_p   (),
        .negedge_p   (),
`ifdef SPI_COND_GLITCH_CNT_EN
        .reject_p    (w_reject[CH_MOSI])
`else
        .reject_p    ()
`endif
    );

`ifdef SPI_COND_GLITCH_CNT_EN
    // Sum is two bits wider than the counter so any overflow is visible
    // in the top bits and can be clamped to all-ones.
    logic [GLITCH_W+1:0] w_glitch_sum;
    logic [GLITCH_W-1:0] r_glitch_cnt;

    assign w_glitch_sum = {2'b00, r_glitch_cnt} + (GLITCH_W+2)'(count3(w_reject));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_glitch_cnt <= '0;
        end else if (|w_glitch_sum[GLITCH_W+1:GLITCH_W]) begin
            r_glitch_cnt <= '1;
        end else begin
            r_glitch_cnt <= w_glitch_sum[GLITCH_W-1:0];
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`endif

endmodule

// File: tb/tb_spi_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_spi_input_conditioner
// Directed stimulus with a scoreboard: each stimulus step that should cause a
// visible output change pushes the expected cycle and output vector
// {sclk_posedge, sclk_negedge, cs_cond, mosi_cond} into a queue; a monitor
// on the falling clock edge pops and compares whenever the outputs change or
// a pulse is present. Glitch-counter checks are built only when
// SPI_COND_GLITCH_CNT_EN is defined (then GLITCH_W=2).
// ---------------------------------------------------------------------------
module tb_spi_input_conditioner;

    localparam int W = 3;

    logic clk;
    logic reset;
    logic sclk_pin;
    logic cs_pin;
    logic mosi_pin;
    logic sclk_posedge;
    logic sclk_negedge;
    logic cs_cond;
    logic mosi_cond;

`ifdef SPI_COND_GLITCH_CNT_EN
    logic [1:0] glitch_cnt;

    spi_input_conditioner #(
        .WAIT_TIME (W),
        .CNT_W     (8),
        .GLITCH_W  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sclk_pin     (sclk_pin),
        .cs_pin       (cs_pin),
        .mosi_pin     (mosi_pin),
        .sclk_posedge (sclk_posedge),
        .sclk_negedge (sclk_negedge),
        .cs_cond      (cs_cond),
        .mosi_cond    (mosi_cond),
        .glitch_cnt   (glitch_cnt)
    );
`else
    spi_input_conditioner #(
        .WAIT_TIME (W),
        .CNT_W     (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sclk_pin     (sclk_pin),
        .cs_pin       (cs_pin),
        .mosi_pin     (mosi_pin),
        .sclk_posedge (sclk_posedge),
        .sclk_negedge (sclk_negedge),
        .cs_cond      (cs_cond),
        .mosi_cond    (mosi_cond)
    );
`endif

    typedef struct {
        int         cyc;
        logic [3:0] v;
    } evt_t;

    evt_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_cs;
    logic prev_mosi;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Pins changed just after a falling edge are first sampled on the next
    // rising edge N = cyc+1; the output updates at edge N+W+1.
    task automatic expect_evt(input logic [3:0] v);
        evt_t e;
        e.cyc = cyc + W + 2;
        e.v   = v;
        q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end else begin
            $display("ok   %s: %0d (t=%0t)", name, act, $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        evt_t e;
        if (reset) begin
            prev_cs   = cs_cond;
            prev_mosi = mosi_cond;
        end else begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event: no output change by cycle %0d, expected vec=%b at cycle %0d",
                         cyc, e.v, e.cyc);
            end
            if (sclk_posedge || sclk_negedge || cs_cond != prev_cs || mosi_cond != prev_mosi) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: vec=%b at cycle %0d, expected no change",
                             {sclk_posedge, sclk_negedge, cs_cond, mosi_cond}, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || e.v != {sclk_posedge, sclk_negedge, cs_cond, mosi_cond}) begin
                        errors++;
                        $display("FAIL event: vec=%b at cycle %0d, expected vec=%b at cycle %0d",
                                 {sclk_posedge, sclk_negedge, cs_cond, mosi_cond}, cyc, e.v, e.cyc);
                    end else begin
                        $display("evt  vec=%b at cycle %0d", e.v, cyc);
                    end
                end
            end
            prev_cs   = cs_cond;
            prev_mosi = mosi_cond;
        end
    end

    initial begin
`ifdef SPI_COND_GLITCH_CNT_EN
        int sat_seq [5] = '{1, 2, 3, 3, 3};
`endif
        reset    = 1'b1;
        sclk_pin = 1'b0;
        cs_pin   = 1'b1;
        mosi_pin = 1'b0;
        #1 check("reset_idle", int'({sclk_posedge, sclk_negedge, cs_cond, mosi_cond}), 4'b0010);
        wait_cycles(3);
        #2 reset = 1'b0;
        wait_cycles(5);

        // 1: drive all pins away from idle, then reset asynchronously.
        @(negedge clk);
        sclk_pin = 1'b1; cs_pin = 1'b0; mosi_pin = 1'b1;
        expect_evt(4'b1001);
        wait_cycles(8);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset_idle", int'({sclk_posedge, sclk_negedge, cs_cond, mosi_cond}), 4'b0010);
        wait_cycles(2);
        // Release with pins still non-idle: treated as real transitions.
        #2 reset = 1'b0;
        expect_evt(4'b1001);
        @(negedge clk);
        #1 check("no_pulse_release_c1", int'({sclk_posedge, sclk_negedge}), 0);
        @(negedge clk);
        #1 check("no_pulse_release_c2", int'({sclk_posedge, sclk_negedge}), 0);
        wait_cycles(8);
        @(negedge clk);
        sclk_pin = 1'b0; cs_pin = 1'b1; mosi_pin = 1'b0;
        expect_evt(4'b0110);
        wait_cycles(8);

        // 2: clean SCLK rise and fall.
        @(negedge clk);
        sclk_pin = 1'b1;
        expect_evt(4'b1010);
        wait_cycles(8);
        @(negedge clk);
        sclk_pin = 1'b0;
        expect_evt(4'b0110);
        wait_cycles(8);

        // Boundary: high for exactly W cycles is accepted.
        @(negedge clk);
        sclk_pin = 1'b1;
        expect_evt(4'b1010);
        wait_cycles(W);
        sclk_pin = 1'b0;
        expect_evt(4'b0110);
        wait_cycles(8);

        // 3: glitches (W-1 cycles on SCLK, 1 cycle on CS) are rejected.
`ifdef SPI_COND_GLITCH_CNT_EN
        check("glitch_cnt_before", int'(glitch_cnt), 0);
`endif
        @(negedge clk);
        sclk_pin = 1'b1;
        wait_cycles(W - 1);
        sclk_pin = 1'b0;
        @(negedge clk);
        cs_pin = 1'b0;
        @(negedge clk);
        cs_pin = 1'b1;
        wait_cycles(8);
`ifdef SPI_COND_GLITCH_CNT_EN
        #1 check("glitch_cnt_after", int'(glitch_cnt), 2);
`endif

        // 4: simultaneous CS fall and MOSI rise, then back.
        @(negedge clk);
        cs_pin = 1'b0; mosi_pin = 1'b1;
        expect_evt(4'b0001);
        wait_cycles(8);
        @(negedge clk);
        cs_pin = 1'b1; mosi_pin = 1'b0;
        expect_evt(4'b0010);
        wait_cycles(8);

        // 5: reset while SCLK rise is mid-filter: no pulse ever.
        @(negedge clk);
        sclk_pin = 1'b1;
        wait_cycles(3);
        #2 reset = 1'b1;
        sclk_pin = 1'b0;
        #1 check("midfilter_reset_idle", int'({sclk_posedge, sclk_negedge, cs_cond, mosi_cond}), 4'b0010);
        wait_cycles(2);
        #2 reset = 1'b0;
        wait_cycles(10);
`ifdef SPI_COND_GLITCH_CNT_EN
        #1 check("glitch_cnt_reset", int'(glitch_cnt), 0);

        // 6: saturation of the 2-bit glitch counter.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sclk_pin = 1'b1;
            @(negedge clk);
            sclk_pin = 1'b0;
            wait_cycles(6);
            #1 check($sformatf("glitch_sat_%0d", i), int'(glitch_cnt), sat_seq[i]);
        end
`endif

        wait_cycles(10);
        #1 check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
